// File: rtl/load_store_unit.sv
// Load/store memory stage: one word-aligned bus transaction per request, with byte lanes, load extension and exceptions.
// Optional watchdog on REQ/WAIT_R enabled by defining LSU_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module load_store_unit #(
  parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        mem_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [4:0]        rd_addr,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              rsp_valid,
  output logic              rsp_is_load,
  output logic [4:0]        rsp_rd,
  output logic [31:0]       rsp_data,
  output logic              rsp_exc,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_R, RESP, EXC} state_t;

  state_t            state_q, state_d;
  logic [1:0]        offset_q, offset_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_load_q, is_load_d;
  logic [4:0]        rd_q, rd_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_is_load_q, rsp_is_load_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_exc_q, rsp_exc_d;

  logic [2:0]  f3_in;
  logic        we_in;
  logic        illegal_in;
  logic        misaligned_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_rep;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic        timeout;

  always_comb begin
    f3_in = mem_w[3:1];
    we_in = mem_w[0];
    if (we_in) illegal_in = (f3_in > 3'd2);
    else       illegal_in = !(f3_in inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misaligned_in = ((f3_in[1:0] == 2'b01) && addr[0]) ||
                    ((f3_in[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (f3_in[1:0])
      2'b00:   begin be_in = 4'b0001 << addr[1:0]; wdata_rep = {4{wdata[7:0]}};  end
      2'b01:   begin be_in = 4'b0011 << addr[1:0]; wdata_rep = {2{wdata[15:0]}}; end
      default: begin be_in = 4'b1111;              wdata_rep = wdata;            end
    endcase
  end

  // Load data is realigned from the captured byte offset, then extended by funct3.
  always_comb begin
    shifted = bus_rdata >> {offset_q, 3'b000};
    case (funct3_q)
      3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_ext = {24'b0, shifted[7:0]};
      3'd5:    load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = ((state_q == REQ) || (state_q == WAIT_R)) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    funct3_d      = funct3_q;
    is_load_d     = is_load_q;
    rd_d          = rd_q;
    req_ready_d   = req_ready_q;
    busy_d        = busy_q;
    bus_valid_d   = bus_valid_q;
    bus_we_d      = bus_we_q;
    bus_be_d      = bus_be_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_is_load_d = 1'b0;
    rsp_rd_d      = '0;
    rsp_data_d    = '0;
    rsp_exc_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          offset_d    = addr[1:0];
          funct3_d    = f3_in;
          is_load_d   = !we_in;
          rd_d        = rd_addr;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (illegal_in || misaligned_in) begin
            state_d       = EXC;
            rsp_valid_d   = 1'b1;
            rsp_exc_d     = 1'b1;
            rsp_is_load_d = !we_in;
            rsp_rd_d      = rd_addr;
          end else begin
            state_d     = REQ;
            bus_valid_d = 1'b1;
            bus_we_d    = we_in;
            bus_be_d    = be_in;
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_wdata_d = we_in ? wdata_rep : 32'b0;
          end
        end
      end
      REQ: begin
        if (bus_ready || timeout) begin
          bus_valid_d = 1'b0;
          bus_we_d    = 1'b0;
          bus_be_d    = '0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
        end
        if (bus_ready) begin
          if (is_load_q) begin
            state_d = WAIT_R;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rd_d    = rd_q;
          end
        end else if (timeout) begin
          state_d       = EXC;
          rsp_valid_d   = 1'b1;
          rsp_exc_d     = 1'b1;
          rsp_is_load_d = is_load_q;
          rsp_rd_d      = rd_q;
        end
      end
      WAIT_R: begin
        if (bus_rvalid) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_is_load_d = 1'b1;
          rsp_rd_d      = rd_q;
          rsp_data_d    = load_ext;
        end else if (timeout) begin
          state_d       = EXC;
          rsp_valid_d   = 1'b1;
          rsp_exc_d     = 1'b1;
          rsp_is_load_d = 1'b1;
          rsp_rd_d      = rd_q;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      offset_q      <= '0;
      funct3_q      <= '0;
      is_load_q     <= 1'b0;
      rd_q          <= '0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      bus_valid_q   <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_be_q      <= '0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_is_load_q <= 1'b0;
      rsp_rd_q      <= '0;
      rsp_data_q    <= '0;
      rsp_exc_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      funct3_q      <= funct3_d;
      is_load_q     <= is_load_d;
      rd_q          <= rd_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      bus_valid_q   <= bus_valid_d;
      bus_we_q      <= bus_we_d;
      bus_be_q      <= bus_be_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_is_load_q <= rsp_is_load_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_data_q    <= rsp_data_d;
      rsp_exc_q     <= rsp_exc_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign bus_valid   = bus_valid_q;
  assign bus_we      = bus_we_q;
  assign bus_be      = bus_be_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_is_load = rsp_is_load_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_exc     = rsp_exc_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads with extension, exceptions, mid-op reset.
// The watchdog scenario runs only when LSU_TIMEOUT_EN is defined (TIMEOUT_CYC overridden to 4).
module tb_load_store_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        mem_w;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [4:0]        rd_addr;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [3:0]        bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;
  logic              rsp_valid;
  logic              rsp_is_load;
  logic [4:0]        rsp_rd;
  logic [31:0]       rsp_data;
  logic              rsp_exc;
  logic              busy;

  int vecCount  = 0;
  int missCount = 0;

  load_store_unit #(
    .ADDR_W(ADDR_W)
`ifdef LSU_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .rd_addr(rd_addr),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_be(bus_be),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_is_load(rsp_is_load), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
    .rsp_exc(rsp_exc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one request for a single cycle, then scramble the request inputs.
  task automatic applyStimulus(input logic [3:0] mw, input logic [31:0] a, input logic [31:0] wd,
                               input logic [4:0] rd);
    checkOutput("req_ready before accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    mem_w     = mw;
    addr      = a;
    wdata     = wd;
    rd_addr   = rd;
    step();
    req_valid = 1'b0;
    mem_w     = ~mw;
    addr      = ~a;
    wdata     = ~wd;
    rd_addr   = ~rd;
  endtask

  task automatic runAccess(input string name, input logic [3:0] mw, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input int ready_delay, input int rvalid_delay, input logic early_rvalid,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_baddr, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_data);
    applyStimulus(mw, a, wd, rd);
    checkOutput({name, " bus_valid"}, 32'(bus_valid), 32'd1);
    checkOutput({name, " bus_we"}, 32'(bus_we), 32'(mw[0]));
    checkOutput({name, " bus_be"}, 32'(bus_be), 32'(exp_be));
    checkOutput({name, " bus_addr"}, bus_addr, exp_baddr);
    if (mw[0]) checkOutput({name, " bus_wdata"}, bus_wdata, exp_wdata);
    checkOutput({name, " busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < ready_delay; i++) begin
      step();
      checkOutput({name, " bus_valid held"}, 32'(bus_valid), 32'd1);
      checkOutput({name, " bus_addr held"}, bus_addr, exp_baddr);
    end
    bus_ready = 1'b1;
    if (early_rvalid) begin
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hBAD0_BAD0;
    end
    step();
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h5A5A_5A5A;
    checkOutput({name, " bus_valid dropped"}, 32'(bus_valid), 32'd0);
    if (mw[0]) begin
      checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({name, " rsp_is_load"}, 32'(rsp_is_load), 32'd0);
      checkOutput({name, " rsp_exc"}, 32'(rsp_exc), 32'd0);
      checkOutput({name, " rsp_data"}, rsp_data, 32'd0);
    end else begin
      for (int i = 1; i < rvalid_delay; i++) begin
        checkOutput({name, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
        step();
      end
      checkOutput({name, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
      bus_rvalid = 1'b1;
      bus_rdata  = rdata;
      step();
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h5A5A_5A5A;
      checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({name, " rsp_is_load"}, 32'(rsp_is_load), 32'd1);
      checkOutput({name, " rsp_rd"}, 32'(rsp_rd), 32'(rd));
      checkOutput({name, " rsp_data"}, rsp_data, exp_data);
      checkOutput({name, " rsp_exc"}, 32'(rsp_exc), 32'd0);
    end
    step();
    checkOutput({name, " rsp_valid pulse"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, " req_ready after"}, 32'(req_ready), 32'd1);
    checkOutput({name, " busy after"}, 32'(busy), 32'd0);
  endtask

  task automatic runExc(input string name, input logic [3:0] mw, input logic [31:0] a,
                        input logic [4:0] rd);
    applyStimulus(mw, a, 32'h1111_2222, rd);
    checkOutput({name, " bus_valid"}, 32'(bus_valid), 32'd0);
    checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({name, " rsp_exc"}, 32'(rsp_exc), 32'd1);
    checkOutput({name, " rsp_data"}, rsp_data, 32'd0);
    checkOutput({name, " rsp_rd"}, 32'(rsp_rd), 32'(rd));
    checkOutput({name, " rsp_is_load"}, 32'(rsp_is_load), 32'(!mw[0]));
    step();
    checkOutput({name, " rsp_valid pulse"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, " rsp_exc clear"}, 32'(rsp_exc), 32'd0);
    checkOutput({name, " req_ready after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    mem_w      = 4'b0;
    addr       = '0;
    wdata      = '0;
    rd_addr    = '0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h5A5A_5A5A;
    step();
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset bus_valid", 32'(bus_valid), 32'd0);
    checkOutput("reset bus_be", 32'(bus_be), 32'd0);
    checkOutput("reset bus_addr", bus_addr, 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    step();

    //        name   mem_w    addr          wdata          rd     rdy rv early rdata          be       baddr         bwdata         data
    runAccess("SW",  4'b0101, 32'h0000_0104, 32'hDEAD_BEEF, 5'd1, 0, 0, 1'b0, 32'h0,         4'b1111, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0);
    runAccess("SB",  4'b0001, 32'h0000_0203, 32'h0000_00A5, 5'd2, 0, 0, 1'b0, 32'h0,         4'b1000, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0);
    runAccess("SH",  4'b0011, 32'h0000_0102, 32'h1234_CAFE, 5'd3, 2, 0, 1'b0, 32'h0,         4'b1100, 32'h0000_0100, 32'hCAFE_CAFE, 32'h0);
    runAccess("LB",  4'b0000, 32'h0000_0301, 32'h0,         5'd7, 0, 3, 1'b1, 32'h1234_8056, 4'b0010, 32'h0000_0300, 32'h0,         32'hFFFF_FF80);
    runAccess("LBU", 4'b1000, 32'h0000_0301, 32'h0,         5'd9, 1, 3, 1'b0, 32'h1234_8056, 4'b0010, 32'h0000_0300, 32'h0,         32'h0000_0080);
    runAccess("LH",  4'b0010, 32'h0000_0402, 32'h0,         5'd4, 0, 1, 1'b0, 32'h8001_7FFF, 4'b1100, 32'h0000_0400, 32'h0,         32'hFFFF_8001);
    runAccess("LHU", 4'b1010, 32'h0000_0402, 32'h0,         5'd5, 0, 2, 1'b0, 32'h8001_7FFF, 4'b1100, 32'h0000_0400, 32'h0,         32'h0000_8001);
    runAccess("LW",  4'b0100, 32'h0000_0408, 32'h0,         5'd31,0, 10,1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0000_0408, 32'h0,         32'hCAFE_F00D);

    runExc("LH misaligned", 4'b0010, 32'h0000_0403, 5'd6);
    runExc("LW misaligned", 4'b0100, 32'h0000_0401, 5'd8);
    runExc("load funct3=3", 4'b0110, 32'h0000_0400, 5'd10);
    runExc("store funct3=4", 4'b1001, 32'h0000_0400, 5'd11);

    // Reset in the third cycle of a stalled load must abort it without a response.
    applyStimulus(4'b0100, 32'h0000_0500, 32'h0, 5'd12);
    checkOutput("abort bus_valid c1", 32'(bus_valid), 32'd1);
    step();
    checkOutput("abort bus_valid c2", 32'(bus_valid), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort bus_valid", 32'(bus_valid), 32'd0);
    checkOutput("abort req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort rsp_valid", 32'(rsp_valid), 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h7777_7777;
    step();
    bus_rvalid = 1'b0;
    checkOutput("abort late rvalid", 32'(rsp_valid), 32'd0);
    step();
    checkOutput("abort late rvalid 2", 32'(rsp_valid), 32'd0);
    checkOutput("abort idle req_ready", 32'(req_ready), 32'd1);

    runAccess("LW after abort", 4'b0100, 32'h0000_050C, 32'h0, 5'd13, 0, 1, 1'b0, 32'h0102_0304,
              4'b1111, 32'h0000_050C, 32'h0, 32'h0102_0304);

`ifdef LSU_TIMEOUT_EN
    // Bus never returns read data: watchdog expires after four cycles in WAIT_R.
    applyStimulus(4'b0100, 32'h0000_0600, 32'h0, 5'd14);
    checkOutput("timeout bus_valid", 32'(bus_valid), 32'd1);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("timeout rsp_valid early", 32'(rsp_valid), 32'd0);
      step();
    end
    checkOutput("timeout rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("timeout rsp_exc", 32'(rsp_exc), 32'd1);
    checkOutput("timeout rsp_data", rsp_data, 32'd0);
    step();
    checkOutput("timeout rsp_valid pulse", 32'(rsp_valid), 32'd0);
    checkOutput("timeout req_ready", 32'(req_ready), 32'd1);
    bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    checkOutput("timeout late rvalid", 32'(rsp_valid), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
